// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the multi-channel DDS generator.
//   dds_mode_t  - 2-bit waveform selector
//   DDS_*       - waveform encodings (sine, square, triangle, sawtooth)
//   ch_width()  - width of a channel-select field for a given channel count
package dds_pkg;

  typedef logic [1:0] dds_mode_t;

  localparam dds_mode_t DDS_SINE   = 2'd0;
  localparam dds_mode_t DDS_SQUARE = 2'd1;
  localparam dds_mode_t DDS_TRI    = 2'd2;
  localparam dds_mode_t DDS_SAW    = 2'd3;

  // A single-channel build still needs a 1-bit select port.
  function automatic int ch_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// dds_sine_lut: quarter-wave sine ROM with quadrant folding. Purely
// combinational; the parent registers the result.
//   phase  [A-1:0] in  : top A bits of the channel phase
//   sample [W-1:0] out : unsigned offset-binary sine sample
module dds_sine_lut #(
  parameter int A = 8,
  parameter int W = 10
) (
  input  logic [A-1:0] phase,
  output logic [W-1:0] sample
);

  localparam int DEPTH = 2 ** (A - 2);
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};
  localparam real PI = 3.14159265358979323846;

  // Entry k samples the first quadrant at (k + 0.5) steps, so the mirrored
  // quadrants land exactly on the same table entries.
  function automatic logic [W-2:0] rom_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (W - 1)) - 1);
    ang = 2.0 * PI * (real'(k) + 0.5) / real'(DEPTH * 4);
    return (W-1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [W-2:0] rom_s [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom_s[k] = rom_entry(k);
  end

  logic [1:0]   quad_s;
  logic [A-3:0] idx_s;
  logic [W-1:0] mag_s;

  // Quadrant folding: odd quadrants run the table backwards, the lower half
  // of the wave is the table reflected below midscale.
  always_comb begin
    quad_s = phase[A-1 -: 2];
    if (quad_s[0]) begin
      idx_s = ~phase[A-3:0];
    end else begin
      idx_s = phase[A-3:0];
    end
    mag_s = {1'b0, rom_s[idx_s]};
    if (quad_s[1]) begin
      sample = MID - mag_s;
    end else begin
      sample = MID + mag_s;
    end
  end

endmodule

// File: rtl/dds_gen_mc.sv
// dds_gen_mc: multi-channel, multi-waveform DDS generator with
// double-buffered configuration and a common commit/sync.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_we/cfg_ch     : shadow write strobe and target channel
//   cfg_fw/cfg_phase  : frequency word / phase offset for the shadow
//   cfg_mode          : waveform for the shadow (sine/square/tri/saw)
//   commit            : copy all shadows to the active registers
//   sync              : zero all phase accumulators
//   q_out             : channel c sample at [c*W +: W]
//   q_valid           : pipeline holds samples from a defined phase
module dds_gen_mc
  import dds_pkg::*;
#(
  parameter int N  = 24,
  parameter int W  = 10,
  parameter int A  = 8,
  parameter int CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [ch_width(CH)-1:0] cfg_ch,
  input  logic [N-1:0]            cfg_fw,
  input  logic [N-1:0]            cfg_phase,
  input  logic [1:0]              cfg_mode,
  input  logic                    commit,
  input  logic                    sync,
  output logic [CH*W-1:0]         q_out,
  output logic                    q_valid
);

  // Only the top phase bits feed any waveform; keep enough for the sine
  // address and for the triangle (which needs W bits below the MSB).
  localparam int K = (A > W + 1) ? A : W + 1;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

  logic [1:0] fill_cnt_r;
  logic       valid_r;

  // Refill tracker: counts edges since reset/sync until both pipeline
  // stages carry data derived from the restarted phase.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      fill_cnt_r <= 2'd0;
      valid_r    <= 1'b0;
    end else begin
      if (fill_cnt_r != 2'd2) begin
        fill_cnt_r <= fill_cnt_r + 2'd1;
      end else begin
        fill_cnt_r <= fill_cnt_r;
      end
      valid_r <= (fill_cnt_r != 2'd0);
    end
  end

  assign q_valid = valid_r;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [N-1:0] fw_sh_r;
    logic [N-1:0] ph_sh_r;
    dds_mode_t    mode_sh_r;
    logic [N-1:0] fw_act_r;
    logic [N-1:0] ph_act_r;
    dds_mode_t    mode_act_r;
    logic [N-1:0] acc_r;
    logic [K-1:0] p_r;
    dds_mode_t    mode_p_r;
    logic [W-1:0] q_r;
    logic [N-1:0] phase_s;
    logic [W-1:0] sine_s;
    logic [W-1:0] wave_s;
    logic         wr_hit_s;

    // Out-of-range channel numbers simply match no lane.
    assign wr_hit_s = cfg_we && (32'(cfg_ch) == 32'(c));
    assign phase_s  = acc_r + ph_act_r;

    // Shadow and active configuration; commit copies the pre-write shadow.
    always_ff @(posedge clk) begin
      if (rst) begin
        fw_sh_r    <= {N{1'b0}};
        ph_sh_r    <= {N{1'b0}};
        mode_sh_r  <= DDS_SINE;
        fw_act_r   <= {N{1'b0}};
        ph_act_r   <= {N{1'b0}};
        mode_act_r <= DDS_SINE;
      end else begin
        if (wr_hit_s) begin
          fw_sh_r   <= cfg_fw;
          ph_sh_r   <= cfg_phase;
          mode_sh_r <= cfg_mode;
        end else begin
          fw_sh_r   <= fw_sh_r;
          ph_sh_r   <= ph_sh_r;
          mode_sh_r <= mode_sh_r;
        end
        if (commit) begin
          fw_act_r   <= fw_sh_r;
          ph_act_r   <= ph_sh_r;
          mode_act_r <= mode_sh_r;
        end else begin
          fw_act_r   <= fw_act_r;
          ph_act_r   <= ph_act_r;
          mode_act_r <= mode_act_r;
        end
      end
    end

    // Phase accumulator; sync drops this cycle's increment.
    always_ff @(posedge clk) begin
      if (rst || sync) begin
        acc_r <= {N{1'b0}};
      end else begin
        acc_r <= acc_r + fw_act_r;
      end
    end

    // Stage 1: offset phase, with the mode travelling alongside it so a
    // committed mode and offset reach the output on the same edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_r      <= {K{1'b0}};
        mode_p_r <= DDS_SINE;
      end else begin
        p_r      <= phase_s[N-1 -: K];
        mode_p_r <= mode_act_r;
      end
    end

    dds_sine_lut #(
      .A (A),
      .W (W)
    ) u_sine (
      .phase  (p_r[K-1 -: A]),
      .sample (sine_s)
    );

    // Waveform shaping from the stage-1 phase.
    always_comb begin
      wave_s = sine_s;
      case (mode_p_r)
        DDS_SINE:   wave_s = sine_s;
        DDS_SQUARE: wave_s = p_r[K-1] ? {W{1'b0}} : {W{1'b1}};
        DDS_TRI:    wave_s = p_r[K-1] ? ~p_r[K-2 -: W] : p_r[K-2 -: W];
        DDS_SAW:    wave_s = p_r[K-1 -: W];
        default:    wave_s = sine_s;
      endcase
    end

    // Stage 2: registered sample; reset parks the lane at midscale.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_r <= MID;
      end else begin
        q_r <= wave_s;
      end
    end

    assign q_out[c*W +: W] = q_r;
  end

endmodule

// File: tb/tb_dds_gen_mc.sv
// tb_dds_gen_mc: self-checking bench for dds_gen_mc (N=24, W=10, A=8, CH=2)
// against a behavioural phase/waveform model, plus a CH=3 instance used to
// exercise writes to a non-existent channel.
module tb_dds_gen_mc;

  localparam int N  = 24;
  localparam int W  = 10;
  localparam int A  = 8;
  localparam int CH = 2;
  localparam int unsigned MASK = 32'h00FF_FFFF;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_ch = 1'b0;
  logic [23:0] cfg_fw = 24'd0;
  logic [23:0] cfg_phase = 24'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        commit = 1'b0;
  logic        sync = 1'b0;
  logic [19:0] q_out;
  logic        q_valid;

  logic        cfg_we3 = 1'b0;
  logic [1:0]  cfg_ch3 = 2'd0;
  logic [23:0] cfg_fw3 = 24'd0;
  logic [23:0] cfg_phase3 = 24'd0;
  logic [1:0]  cfg_mode3 = 2'd0;
  logic        commit3 = 1'b0;
  logic        sync3 = 1'b0;
  logic [29:0] q_out3;
  logic        q_valid3;

  always #5 clk = ~clk;

  dds_gen_mc #(.N(N), .W(W), .A(A), .CH(CH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_fw(cfg_fw),
    .cfg_phase(cfg_phase), .cfg_mode(cfg_mode), .commit(commit), .sync(sync),
    .q_out(q_out), .q_valid(q_valid)
  );

  dds_gen_mc #(.N(N), .W(W), .A(A), .CH(3)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_fw(cfg_fw3),
    .cfg_phase(cfg_phase3), .cfg_mode(cfg_mode3), .commit(commit3), .sync(sync3),
    .q_out(q_out3), .q_valid(q_valid3)
  );

  int total = 0;
  int bad = 0;

  // Reference model state (main instance)
  int unsigned m_acc [CH];
  int unsigned m_fw  [CH];
  int unsigned m_ph  [CH];
  logic [1:0]  m_mode[CH];
  int unsigned s_fw  [CH];
  int unsigned s_ph  [CH];
  logic [1:0]  s_mode[CH];
  logic [19:0] pipe0, pipe1, q_exp;
  logic        v_exp;
  int          since;

  // Ideal waveform value for a 24-bit phase.
  function automatic logic [9:0] wave(input logic [1:0] md, input int unsigned p);
    int unsigned pa;
    real s;
    case (md)
      2'd0: begin
        pa = p >> 16;
        s = 511.0 * $sin(2.0 * PI * (real'(pa) + 0.5) / 256.0);
        if (s >= 0.0) wave = 10'(512 + $rtoi(s + 0.5));
        else          wave = 10'(512 - $rtoi(0.5 - s));
      end
      2'd1:    wave = (p >= 32'h0080_0000) ? 10'd0 : 10'd1023;
      2'd2:    wave = (p < 32'h0080_0000) ? 10'(p >> 13)
                                          : 10'(1023 - ((p - 32'h0080_0000) >> 13));
      default: wave = 10'(p >> 14);
    endcase
  endfunction

  function automatic logic [19:0] sample_all();
    logic [19:0] r;
    for (int c = 0; c < CH; c++)
      r[c*10 +: 10] = wave(m_mode[c], (m_acc[c] + m_ph[c]) & MASK);
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_fw[c] = 0; m_ph[c] = 0; m_mode[c] = 2'd0;
        s_fw[c] = 0; s_ph[c] = 0; s_mode[c] = 2'd0;
      end
      q_exp = {10'd512, 10'd512};
      pipe0 = sample_all();
      pipe1 = pipe0;
      since = 0;
      v_exp = 1'b0;
    end else begin
      q_exp = pipe1;
      pipe1 = pipe0;
      for (int c = 0; c < CH; c++)
        m_acc[c] = sync ? 0 : ((m_acc[c] + m_fw[c]) & MASK);
      if (commit) begin
        for (int c = 0; c < CH; c++) begin
          m_fw[c] = s_fw[c]; m_ph[c] = s_ph[c]; m_mode[c] = s_mode[c];
        end
      end
      if (cfg_we && (int'(cfg_ch) < CH)) begin
        s_fw[cfg_ch] = cfg_fw; s_ph[cfg_ch] = cfg_phase; s_mode[cfg_ch] = cfg_mode;
      end
      since = sync ? 0 : ((since < 2) ? since + 1 : since);
      v_exp = (since >= 2);
      pipe0 = sample_all();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg_write(input logic [0:0] ch, input int unsigned fw,
                           input int unsigned ph, input logic [1:0] md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_fw = fw[23:0]; cfg_phase = ph[23:0]; cfg_mode = md;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q_out !== 20'({10'd512, 10'd512}) || q_valid !== 1'b0) begin
        bad++; $display("FAIL reset_hold cyc=%0d q=%h valid=%b exp q=%h valid=0", i, q_out, q_valid, {10'd512, 10'd512});
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_early got=%b exp=0", q_valid); end
    tick();
    total++;
    if (q_valid !== 1'b1) begin bad++; $display("FAIL reset_valid_rise got=%b exp=1", q_valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL reset_idle cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
    end
  endtask

  task automatic test_saw();
    logic [9:0] prev;
    cfg_write(1'b0, 32'h0001_0000, 0, 2'd3);
    commit = 1'b1; tick(); commit = 1'b0;
    prev = 10'd0;
    for (int i = 0; i < 300; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL saw_model cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
      if (i >= 2) begin
        total++;
        if (q_out[9:0] !== prev + 10'd4) begin
          bad++; $display("FAIL saw_step cyc=%0d got=%0d exp=%0d", i, q_out[9:0], prev + 10'd4);
        end
        total++;
        if (q_out[19:10] !== 10'd518) begin
          bad++; $display("FAIL saw_ch1_idle cyc=%0d got=%0d exp=518", i, q_out[19:10]);
        end
      end
      prev = q_out[9:0];
    end
  endtask

  task automatic test_square();
    int highs;
    cfg_write(1'b1, 32'h0010_0000, 0, 2'd1);
    commit = 1'b1; tick(); commit = 1'b0;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL square_model cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
      if (i >= 1 && i <= 32 && q_out[19:10] == 10'd1023) highs++;
    end
    total++;
    if (highs != 16) begin bad++; $display("FAIL square_duty got=%0d exp=16", highs); end
  endtask

  task automatic test_quadrature();
    logic [9:0] c0 [200];
    logic [9:0] c1 [200];
    cfg_write(1'b0, 32'h0001_0000, 0, 2'd0);
    cfg_write(1'b1, 32'h0001_0000, 32'h0040_0000, 2'd0);
    commit = 1'b1; sync = 1'b1; tick(); commit = 1'b0; sync = 1'b0;
    total++;
    if (q_valid !== 1'b0) begin bad++; $display("FAIL quad_valid_drop got=%b exp=0", q_valid); end
    tick();
    total++;
    if (q_valid !== 1'b0) begin bad++; $display("FAIL quad_valid_hold got=%b exp=0", q_valid); end
    for (int k = 0; k < 200; k++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL quad_model k=%0d q=%h/%b exp=%h/%b", k, q_out, q_valid, q_exp, v_exp);
      end
      c0[k] = q_out[9:0];
      c1[k] = q_out[19:10];
    end
    total++;
    if (c1[0] !== 10'd1023) begin bad++; $display("FAIL quad_ch1_peak got=%0d exp=1023", c1[0]); end
    total++;
    if (c0[64] !== 10'd1023) begin bad++; $display("FAIL quad_ch0_peak got=%0d exp=1023", c0[64]); end
    total++;
    if (11'(c0[0]) + 11'(c0[128]) != 11'd1024) begin
      bad++; $display("FAIL quad_zero_sym got=%0d+%0d exp sum 1024", c0[0], c0[128]);
    end
    for (int k = 0; k < 136; k++) begin
      total++;
      if (c1[k] !== c0[k + 64]) begin
        bad++; $display("FAIL quad_lead k=%0d ch1=%0d ch0+64=%0d", k, c1[k], c0[k + 64]);
      end
    end
  endtask

  task automatic test_buffering();
    logic [9:0] h [1000];
    cfg_write(1'b0, 32'h0004_0000, 0, 2'd0);
    for (int i = 0; i < 1000; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL buf_model cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
      h[i] = q_out[9:0];
      if (i >= 256) begin
        total++;
        if (h[i] !== h[i - 256]) begin
          bad++; $display("FAIL buf_period cyc=%0d got=%0d exp=%0d", i, h[i], h[i - 256]);
        end
      end
    end
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_fw = 24'h001000; cfg_phase = 24'd0; cfg_mode = 2'd0;
    commit = 1'b1; tick(); cfg_we = 1'b0; commit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL buf_same_cycle cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
    end
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL buf_second_commit cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
    end
  endtask

  task automatic test_ignore();
    logic [9:0] prev3;
    cfg_we3 = 1'b1; cfg_ch3 = 2'd0; cfg_fw3 = 24'h010000; cfg_phase3 = 24'd0; cfg_mode3 = 2'd3;
    tick();
    cfg_ch3 = 2'd3; cfg_fw3 = 24'h100000; cfg_phase3 = 24'h400000; cfg_mode3 = 2'd1;
    tick();
    cfg_we3 = 1'b0; commit3 = 1'b1; tick(); commit3 = 1'b0;
    tick(); tick();
    total++;
    if (q_out3[9:0] !== 10'd0) begin bad++; $display("FAIL ignore_saw_start got=%0d exp=0", q_out3[9:0]); end
    prev3 = q_out3[9:0];
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (q_out3[9:0] !== prev3 + 10'd4) begin
        bad++; $display("FAIL ignore_ch0 cyc=%0d got=%0d exp=%0d", i, q_out3[9:0], prev3 + 10'd4);
      end
      total++;
      if (q_out3[29:10] !== {10'd518, 10'd518}) begin
        bad++; $display("FAIL ignore_ch12 cyc=%0d got=%h exp=%h", i, q_out3[29:10], {10'd518, 10'd518});
      end
      prev3 = q_out3[9:0];
    end
  endtask

  task automatic test_mid_operation();
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if (q_out !== 20'({10'd512, 10'd512}) || q_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset q=%h valid=%b exp q=%h valid=0", q_out, q_valid, {10'd512, 10'd512});
    end
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp || q_out !== 20'({10'd518, 10'd518})) begin
        bad++; $display("FAIL mid_cfg_cleared cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
    end
    cfg_write(1'b0, 32'h0001_0000, 0, 2'd3);
    commit = 1'b1; tick(); commit = 1'b0;
    repeat (40) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    total++;
    if (q_valid !== 1'b0) begin bad++; $display("FAIL sync_valid_drop got=%b exp=0", q_valid); end
    tick();
    total++;
    if (q_valid !== 1'b0) begin bad++; $display("FAIL sync_valid_hold got=%b exp=0", q_valid); end
    tick();
    total++;
    if (q_valid !== 1'b1 || q_out[9:0] !== 10'd0) begin
      bad++; $display("FAIL sync_restart valid=%b saw=%0d exp valid=1 saw=0", q_valid, q_out[9:0]);
    end
    tick();
    total++;
    if (q_out[9:0] !== 10'd4 || q_out !== q_exp) begin
      bad++; $display("FAIL sync_step q=%h exp=%h", q_out, q_exp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_fw    = 24'($urandom);
      cfg_phase = 24'($urandom);
      cfg_mode  = 2'($urandom);
      commit    = ($urandom_range(0, 15) == 0);
      sync      = ($urandom_range(0, 31) == 0);
      tick();
      total++;
      if (q_out !== q_exp || q_valid !== v_exp) begin
        bad++; $display("FAIL random cyc=%0d q=%h/%b exp=%h/%b", i, q_out, q_valid, q_exp, v_exp);
      end
    end
    cfg_we = 1'b0; commit = 1'b0; sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square();
    test_quadrature();
    test_buffering();
    test_ignore();
    test_mid_operation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
